rvfi_commit_packer: RTL
=======================

# rvfi_commit_packer

Producer side of the RVFI commit stream for the out-of-order core. It collects per-instruction trace fields as each ROB entry is dispatched, executed and completes memory access. On in-order commit it emits one registered RVFI packet carrying a monotonically increasing order number and the halt indication. Its outputs drive the `rvfi_itf` signals consumed by the RISC-V formal monitor and the halting logic.

## Interface
- `ROB_DEPTH`, default 8: number of ROB entries tracked; power of two, ≥2. `IDX_W = $clog2(ROB_DEPTH)`.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-low reset (`rst==0` resets on `posedge clk`).
- `disp_valid` / `disp_idx` / `disp_pc` / `disp_inst` in 1/IDX_W/32/32: capture a new entry.
- `disp_rs1_addr` / `disp_rs2_addr` / `disp_rd_addr` in 5/5/5: register addresses of the dispatched instruction.
- `wb_valid` / `wb_idx` in 1/IDX_W: execute writeback for an entry.
- `wb_rs1_rdata` / `wb_rs2_rdata` / `wb_rd_wdata` / `wb_pc_wdata` in 32 each: operand values, result and next PC.
- `wb_load_regfile` / `wb_trap` in 1/1: writeback-enable and trap flags.
- `mem_valid` / `mem_idx` in 1/IDX_W: memory completion for an entry.
- `mem_addr` / `mem_rdata` / `mem_wdata` in 32 each; `mem_rmask` / `mem_wmask` in 4/4: memory access fields.
- `commit_valid` / `commit_idx` in 1/IDX_W: ROB head retires this entry.
- `flush` in 1: pipeline flush.
- `rvfi_commit` out 1: packet valid.
- `rvfi_order` out 64: order number of the packet.
- `rvfi_inst` / `rvfi_pc_rdata` / `rvfi_pc_wdata` out 32 each.
- `rvfi_rs1_addr` / `rvfi_rs2_addr` / `rvfi_rd_addr` out 5 each; `rvfi_rs1_rdata` / `rvfi_rs2_rdata` / `rvfi_rd_wdata` out 32 each.
- `rvfi_load_regfile` / `rvfi_trap` out 1/1.
- `rvfi_mem_addr` / `rvfi_mem_rdata` / `rvfi_mem_wdata` out 32 each; `rvfi_mem_rmask` / `rvfi_mem_wmask` out 4/4.
- `rvfi_halt` out 1: halt indication.
- `err_commit_invalid` out 1: one-cycle pulse when a commit targets an empty entry.

## Operation
- Storage: `ROB_DEPTH` entries, each an `rvfi_entry_t` plus three bits: `valid`, `wb_done`, `mem_done`.
- Dispatch writes `pc`, `inst` and register addresses, sets `valid`, and clears every other field and done bit to 0.
- Writeback writes the operand, result, next-PC, `load_regfile` and `trap` fields and sets `wb_done`.
- Mem writes the address, mask and data fields and sets `mem_done`.
- Writeback and mem to the same index in the same cycle both apply, since they write disjoint fields.
- Commit of a valid entry:
  - Registers a packet with `rvfi_order` equal to the current counter, then increments the counter.
  - Clears the entry's `valid`.
  - `rvfi_rd_addr` and `rvfi_rd_wdata` are driven to 0 when `load_regfile==0`. The `rd_wdata` value is also forced to 0 when `rd_addr==0`.
- Commit of an invalid entry: no packet, `err_commit_invalid=1` for one cycle, counter unchanged.
- Halt detection: a committed packet with `pc_wdata == pc_rdata` (branch/jump to itself) sets `rvfi_halt=1` in the same output cycle as that packet.
  - `rvfi_halt` is sticky until reset.
  - Every commit after halt is dropped: no `rvfi_commit`, no counter change.
- Flush clears all `valid` and done bits. It does not affect the order counter or halt.
  - A commit in the same cycle as flush is still emitted, because the ROB head retires before the flush takes effect.
  - A dispatch in the same cycle as flush is discarded.
- Counter width is 64 bits and wraps naturally; wrap is never reached in practice.

## Timing
- Reset values: every output is 0, the order counter is 0, and all `valid`/done bits are 0.
- Commit latency: packet outputs are registered and appear one cycle after `commit_valid`. `rvfi_commit` is high for exactly one cycle per accepted commit.
- Back-to-back commits on consecutive cycles give consecutive packets with orders n, n+1.
- Bypass: when `wb_valid` or `mem_valid` targets `commit_idx` in the same cycle as commit, the incoming values (not the stale stored ones) appear in the packet.
- Dispatch to `commit_idx` in the same cycle: the commit reads the old contents, and the dispatch then installs the new entry with `valid=1`.
- Reset mid-stream: after reset the counter restarts at 0 and any in-flight packet is discarded.

## Structure
- `rvfi_pkg`: `rvfi_entry_t` struct (pc, inst, reg addrs, rdata/wdata, pc_wdata, load_regfile, trap, mem addr/masks/data) and the `ORDER_W=64` constant.
- No sub-module. Entry storage is a flopped array inside this block, sized for multi-field same-cycle writes.

## Test plan
- Dispatch idx 0 (pc `0x60`, `addi x1,x0,5`), writeback rd_wdata=5, commit idx 0 → one cycle later: `rvfi_commit=1`, order 0, rd_addr 1, rd_wdata 5, pc_wdata `0x64`.
- Dispatch idx 2 with rd=0, writeback `load_regfile=1`, rd_wdata `0xAB`, commit → rd_addr 0, rd_wdata 0.
- Store at idx 1: mem addr `0x100`, wmask `4'b0011`, wdata `0x1234`, with writeback and commit issued the same cycle as mem → packet shows the bypassed mem fields. A following 3 back-to-back commits → orders 1, 2, 3.
- Commit an entry whose writeback has pc_wdata == pc_rdata = `0x80` → `rvfi_halt=1` with that packet. A subsequent valid commit produces no `rvfi_commit` and halt stays 1.
- Flush with 4 entries valid, then commit idx 3 → `err_commit_invalid` pulses and the order counter is unchanged.
- Drive `rst=0` for 1 cycle after 5 commits → all outputs 0. The next commit carries order 0.

Source files
------------

// File: rtl/rvfi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_pkg
// Description : Shared types for the RVFI commit packer (trace entry, widths)
// Revision    : 1.0 - initial release
// ============================================================================
package rvfi_pkg;

    localparam int ORDER_W = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic        load_regfile;
        logic        trap;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_entry_t;

    // A packet only reports a destination register when it really writes one,
    // and x0 always reads back as zero.
    function automatic rvfi_entry_t rvfi_mask_rd(input rvfi_entry_t e);
        rvfi_entry_t r;
        r = e;
        if (!e.load_regfile) begin
            r.rd_addr  = '0;
            r.rd_wdata = '0;
        end else if (e.rd_addr == 5'd0) begin
            r.rd_wdata = '0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_commit_packer.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_commit_packer
// Description : Collects per-ROB-entry trace fields and emits one registered
//               RVFI packet per in-order commit, with order count and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_commit_packer
    import rvfi_pkg::*;
#(
    parameter  int ROB_DEPTH = 8,
    localparam int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               disp_valid,
    input  logic [IDX_W-1:0]   disp_idx,
    input  logic [31:0]        disp_pc,
    input  logic [31:0]        disp_inst,
    input  logic [4:0]         disp_rs1_addr,
    input  logic [4:0]         disp_rs2_addr,
    input  logic [4:0]         disp_rd_addr,

    input  logic               wb_valid,
    input  logic [IDX_W-1:0]   wb_idx,
    input  logic [31:0]        wb_rs1_rdata,
    input  logic [31:0]        wb_rs2_rdata,
    input  logic [31:0]        wb_rd_wdata,
    input  logic [31:0]        wb_pc_wdata,
    input  logic               wb_load_regfile,
    input  logic               wb_trap,

    input  logic               mem_valid,
    input  logic [IDX_W-1:0]   mem_idx,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_rdata,
    input  logic [31:0]        mem_wdata,
    input  logic [3:0]         mem_rmask,
    input  logic [3:0]         mem_wmask,

    input  logic               commit_valid,
    input  logic [IDX_W-1:0]   commit_idx,
    input  logic               flush,

    output logic               rvfi_commit,
    output logic [ORDER_W-1:0] rvfi_order,
    output logic [31:0]        rvfi_inst,
    output logic [31:0]        rvfi_pc_rdata,
    output logic [31:0]        rvfi_pc_wdata,
    output logic [4:0]         rvfi_rs1_addr,
    output logic [4:0]         rvfi_rs2_addr,
    output logic [4:0]         rvfi_rd_addr,
    output logic [31:0]        rvfi_rs1_rdata,
    output logic [31:0]        rvfi_rs2_rdata,
    output logic [31:0]        rvfi_rd_wdata,
    output logic               rvfi_load_regfile,
    output logic               rvfi_trap,
    output logic [31:0]        rvfi_mem_addr,
    output logic [31:0]        rvfi_mem_rdata,
    output logic [31:0]        rvfi_mem_wdata,
    output logic [3:0]         rvfi_mem_rmask,
    output logic [3:0]         rvfi_mem_wmask,
    output logic               rvfi_halt,
    output logic               err_commit_invalid
);

    rvfi_entry_t          r_entries [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_wb_done;
    logic [ROB_DEPTH-1:0] r_mem_done;
    logic [ORDER_W-1:0]   r_order;

    rvfi_entry_t w_stored;
    rvfi_entry_t w_commit_entry;
    rvfi_entry_t w_pkt;
    rvfi_entry_t w_disp_entry;
    logic        w_wb_hit;
    logic        w_mem_hit;
    logic        w_accept;
    logic        w_invalid;
    logic        w_halt_hit;

    assign w_stored  = r_entries[commit_idx];
    assign w_wb_hit  = wb_valid  && (wb_idx  == commit_idx);
    assign w_mem_hit = mem_valid && (mem_idx == commit_idx);
    assign w_accept  = commit_valid &&  r_valid[commit_idx] && !rvfi_halt;
    assign w_invalid = commit_valid && !r_valid[commit_idx];

    // Commit view of the head entry: same-cycle writeback/mem results win over
    // stored fields, and stages that never completed contribute zeros.
    always_comb begin
        w_commit_entry              = '0;
        w_commit_entry.pc           = w_stored.pc;
        w_commit_entry.inst         = w_stored.inst;
        w_commit_entry.rs1_addr     = w_stored.rs1_addr;
        w_commit_entry.rs2_addr     = w_stored.rs2_addr;
        w_commit_entry.rd_addr      = w_stored.rd_addr;
        if (w_wb_hit) begin
            w_commit_entry.rs1_rdata    = wb_rs1_rdata;
            w_commit_entry.rs2_rdata    = wb_rs2_rdata;
            w_commit_entry.rd_wdata     = wb_rd_wdata;
            w_commit_entry.pc_wdata     = wb_pc_wdata;
            w_commit_entry.load_regfile = wb_load_regfile;
            w_commit_entry.trap         = wb_trap;
        end else if (r_wb_done[commit_idx]) begin
            w_commit_entry.rs1_rdata    = w_stored.rs1_rdata;
            w_commit_entry.rs2_rdata    = w_stored.rs2_rdata;
            w_commit_entry.rd_wdata     = w_stored.rd_wdata;
            w_commit_entry.pc_wdata     = w_stored.pc_wdata;
            w_commit_entry.load_regfile = w_stored.load_regfile;
            w_commit_entry.trap         = w_stored.trap;
        end
        if (w_mem_hit) begin
            w_commit_entry.mem_addr  = mem_addr;
            w_commit_entry.mem_rmask = mem_rmask;
            w_commit_entry.mem_wmask = mem_wmask;
            w_commit_entry.mem_rdata = mem_rdata;
            w_commit_entry.mem_wdata = mem_wdata;
        end else if (r_mem_done[commit_idx]) begin
            w_commit_entry.mem_addr  = w_stored.mem_addr;
            w_commit_entry.mem_rmask = w_stored.mem_rmask;
            w_commit_entry.mem_wmask = w_stored.mem_wmask;
            w_commit_entry.mem_rdata = w_stored.mem_rdata;
            w_commit_entry.mem_wdata = w_stored.mem_wdata;
        end
    end

    assign w_pkt      = rvfi_mask_rd(w_commit_entry);
    assign w_halt_hit = w_accept && (w_commit_entry.pc_wdata == w_commit_entry.pc);

    always_comb begin
        w_disp_entry          = '0;
        w_disp_entry.pc       = disp_pc;
        w_disp_entry.inst     = disp_inst;
        w_disp_entry.rs1_addr = disp_rs1_addr;
        w_disp_entry.rs2_addr = disp_rs2_addr;
        w_disp_entry.rd_addr  = disp_rd_addr;
    end

    // Field storage; a dispatch to an index overrides any same-cycle field write.
    always_ff @(posedge clk) begin
        if (wb_valid) begin
            r_entries[wb_idx].rs1_rdata    <= wb_rs1_rdata;
            r_entries[wb_idx].rs2_rdata    <= wb_rs2_rdata;
            r_entries[wb_idx].rd_wdata     <= wb_rd_wdata;
            r_entries[wb_idx].pc_wdata     <= wb_pc_wdata;
            r_entries[wb_idx].load_regfile <= wb_load_regfile;
            r_entries[wb_idx].trap         <= wb_trap;
        end
        if (mem_valid) begin
            r_entries[mem_idx].mem_addr  <= mem_addr;
            r_entries[mem_idx].mem_rmask <= mem_rmask;
            r_entries[mem_idx].mem_wmask <= mem_wmask;
            r_entries[mem_idx].mem_rdata <= mem_rdata;
            r_entries[mem_idx].mem_wdata <= mem_wdata;
        end
        if (disp_valid && !flush) begin
            r_entries[disp_idx] <= w_disp_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= '0;
            r_wb_done  <= '0;
            r_mem_done <= '0;
        end else if (flush) begin
            r_valid    <= '0;
            r_wb_done  <= '0;
            r_mem_done <= '0;
        end else begin
            if (wb_valid)  r_wb_done[wb_idx]   <= 1'b1;
            if (mem_valid) r_mem_done[mem_idx] <= 1'b1;
            if (w_accept)  r_valid[commit_idx] <= 1'b0;
            if (disp_valid) begin
                r_valid[disp_idx]    <= 1'b1;
                r_wb_done[disp_idx]  <= 1'b0;
                r_mem_done[disp_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_order            <= '0;
            rvfi_commit        <= 1'b0;
            err_commit_invalid <= 1'b0;
            rvfi_halt          <= 1'b0;
            rvfi_order         <= '0;
            rvfi_inst          <= '0;
            rvfi_pc_rdata      <= '0;
            rvfi_pc_wdata      <= '0;
            rvfi_rs1_addr      <= '0;
            rvfi_rs2_addr      <= '0;
            rvfi_rd_addr       <= '0;
            rvfi_rs1_rdata     <= '0;
            rvfi_rs2_rdata     <= '0;
            rvfi_rd_wdata      <= '0;
            rvfi_load_regfile  <= 1'b0;
            rvfi_trap          <= 1'b0;
            rvfi_mem_addr      <= '0;
            rvfi_mem_rdata     <= '0;
            rvfi_mem_wdata     <= '0;
            rvfi_mem_rmask     <= '0;
            rvfi_mem_wmask     <= '0;
        end else begin
            rvfi_commit        <= w_accept;
            err_commit_invalid <= w_invalid;
            if (w_halt_hit) rvfi_halt <= 1'b1;
            if (w_accept) begin
                r_order           <= r_order + 1'b1;
                rvfi_order        <= r_order;
                rvfi_inst         <= w_pkt.inst;
                rvfi_pc_rdata     <= w_pkt.pc;
                rvfi_pc_wdata     <= w_pkt.pc_wdata;
                rvfi_rs1_addr     <= w_pkt.rs1_addr;
                rvfi_rs2_addr     <= w_pkt.rs2_addr;
                rvfi_rd_addr      <= w_pkt.rd_addr;
                rvfi_rs1_rdata    <= w_pkt.rs1_rdata;
                rvfi_rs2_rdata    <= w_pkt.rs2_rdata;
                rvfi_rd_wdata     <= w_pkt.rd_wdata;
                rvfi_load_regfile <= w_pkt.load_regfile;
                rvfi_trap         <= w_pkt.trap;
                rvfi_mem_addr     <= w_pkt.mem_addr;
                rvfi_mem_rdata    <= w_pkt.mem_rdata;
                rvfi_mem_wdata    <= w_pkt.mem_wdata;
                rvfi_mem_rmask    <= w_pkt.mem_rmask;
                rvfi_mem_wmask    <= w_pkt.mem_wmask;
            end
        end
    end

endmodule
`default_nettype wire
